// File: rtl/tap_data_regs.sv
`timescale 1ns/1ps
// JTAG TAP instruction register plus IDCODE, USER and BYPASS data registers.
// TDO is launched on the falling edge of tck.
module tap_data_regs #(
    parameter int unsigned IR_WIDTH   = 5,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0A6F,
    parameter int unsigned USER_WIDTH = 32
) (
    input  logic                  tck_i,
    input  logic                  trst_i,
    input  logic                  tdi_i,
    input  logic                  captureIR_i,
    input  logic                  shiftIR_i,
    input  logic                  updateIR_i,
    input  logic                  captureDR_i,
    input  logic                  shiftDR_i,
    input  logic                  updateDR_i,
    input  logic                  SelectIR_i,
    input  logic                  Enable_i,
    input  logic [USER_WIDTH-1:0] user_rdata_i,
    output logic                  tdo_o,
    output logic                  tdo_oe_o,
    output logic [IR_WIDTH-1:0]   ir_o,
    output logic [USER_WIDTH-1:0] user_wdata_o,
    output logic                  user_update_o
);

    // Any code other than IDCODE or USER falls through to BYPASS.
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
    localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(5'h10);

    logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [31:0]           idcode_sr_q, idcode_sr_d;
    logic [USER_WIDTH-1:0] user_sr_q, user_sr_d;
    logic                  bypass_q, bypass_d;
    logic [USER_WIDTH-1:0] user_wdata_q, user_wdata_d;
    logic                  user_update_q, user_update_d;
    logic                  tdo_q;

    logic sel_idcode, sel_user;
    logic dr_shift, dr_update, user_fire;
    logic serial_out;

    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_user   = (ir_q == IR_USER);

    // Capture beats shift beats update if the controller ever asserts several.
    assign dr_shift  = shiftDR_i & ~captureDR_i;
    assign dr_update = updateDR_i & ~captureDR_i & ~shiftDR_i;
    assign user_fire = dr_update & sel_user;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        ir_sr_d = ir_sr_q;
        ir_d    = ir_q;
        if (captureIR_i) begin
            ir_sr_d = IR_WIDTH'(2'b01);
        end else if (shiftIR_i) begin
            ir_sr_d = {tdi_i, ir_sr_q[IR_WIDTH-1:1]};
        end else if (updateIR_i) begin
            ir_d = ir_sr_q;
        end
    end

    always_comb begin
        idcode_sr_d = idcode_sr_q;
        user_sr_d   = user_sr_q;
        bypass_d    = bypass_q;
        if (captureDR_i) begin
            if (sel_idcode)    idcode_sr_d = IDCODE_VAL;
            else if (sel_user) user_sr_d   = user_rdata_i;
            else               bypass_d    = 1'b0;
        end else if (dr_shift) begin
            if (sel_idcode)    idcode_sr_d = {tdi_i, idcode_sr_q[31:1]};
            else if (sel_user) user_sr_d   = {tdi_i, user_sr_q[USER_WIDTH-1:1]};
            else               bypass_d    = tdi_i;
        end
    end

    // The strobe is masked by its own previous value so it can never stretch.
    assign user_wdata_d  = user_fire ? user_sr_q : user_wdata_q;
    assign user_update_d = user_fire & ~user_update_q;

    always_ff @(posedge tck_i or posedge trst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (trst_i) begin
            ir_sr_q       <= IR_WIDTH'(1'b1);
            ir_q          <= IR_IDCODE;
            idcode_sr_q   <= '0;
            user_sr_q     <= '0;
            bypass_q      <= 1'b0;
            user_wdata_q  <= '0;
            user_update_q <= 1'b0;
        end else begin
            ir_sr_q       <= ir_sr_d;
            ir_q          <= ir_d;
            idcode_sr_q   <= idcode_sr_d;
            user_sr_q     <= user_sr_d;
            bypass_q      <= bypass_d;
            user_wdata_q  <= user_wdata_d;
            user_update_q <= user_update_d;
        end
    end

    always_comb begin
        serial_out = bypass_q;
        if (SelectIR_i)      serial_out = ir_sr_q[0];
        else if (sel_idcode) serial_out = idcode_sr_q[0];
        else if (sel_user)   serial_out = user_sr_q[0];
    end

    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) tdo_q <= 1'b0;
        else        tdo_q <= serial_out;
    end

    assign tdo_o         = tdo_q;
    assign tdo_oe_o      = Enable_i;
    assign ir_o          = ir_q;
    assign user_wdata_o  = user_wdata_q;
    assign user_update_o = user_update_q;

endmodule

// File: tb/tb_tap_data_regs.sv
`timescale 1ns/1ps
// Directed bench for tap_data_regs: expected TDO bits are queued at capture
// time and popped as each bit appears on tdo_o.
module tb_tap_data_regs;

    localparam int unsigned IR_WIDTH   = 5;
    localparam logic [31:0] IDCODE_VAL = 32'h1000_0A6F;
    localparam int unsigned USER_WIDTH = 32;

    logic tck = 1'b0;
    logic trst = 1'b0;
    logic tdi = 1'b0;
    logic captureIR = 1'b0, shiftIR = 1'b0, updateIR = 1'b0;
    logic captureDR = 1'b0, shiftDR = 1'b0, updateDR = 1'b0;
    logic SelectIR = 1'b0, Enable = 1'b1;
    logic [USER_WIDTH-1:0] user_rdata = '0;
    logic                  tdo, tdo_oe, user_update;
    logic [IR_WIDTH-1:0]   ir;
    logic [USER_WIDTH-1:0] user_wdata;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];
    logic [31:0] dout;

    always #5 tck = ~tck;

    tap_data_regs #(
        .IR_WIDTH   (IR_WIDTH),
        .IDCODE_VAL (IDCODE_VAL),
        .USER_WIDTH (USER_WIDTH)
    ) dut (
        .tck_i         (tck),
        .trst_i        (trst),
        .tdi_i         (tdi),
        .captureIR_i   (captureIR),
        .shiftIR_i     (shiftIR),
        .updateIR_i    (updateIR),
        .captureDR_i   (captureDR),
        .shiftDR_i     (shiftDR),
        .updateDR_i    (updateDR),
        .SelectIR_i    (SelectIR),
        .Enable_i      (Enable),
        .user_rdata_i  (user_rdata),
        .tdo_o         (tdo),
        .tdo_oe_o      (tdo_oe),
        .ir_o          (ir),
        .user_wdata_o  (user_wdata),
        .user_update_o (user_update)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One TAP state: inputs already driven, settle past the posedge and the tdo negedge.
    task automatic tick();
        @(posedge tck);
        @(negedge tck);
        #2;
    endtask

    task automatic sample_tdo(input string tag);
        n_checks++;
        assert (exp_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected a queued bit", tag);
        end
        if (exp_q.size() != 0) check(tag, 32'(tdo), 32'(exp_q.pop_front()));
    endtask

    task automatic ir_scan(input logic [IR_WIDTH-1:0] val);
        SelectIR  = 1'b1;
        captureIR = 1'b1;
        tick();
        captureIR = 1'b0;
        // Captured 0..01 shifts out LSB first: 1 then zeros.
        for (int i = 0; i < int'(IR_WIDTH); i++) exp_q.push_back(i == 0);
        for (int i = 0; i < int'(IR_WIDTH); i++) begin
            sample_tdo("ir_tdo");
            shiftIR = 1'b1;
            tdi     = val[i];
            tick();
        end
        shiftIR  = 1'b0;
        updateIR = 1'b1;
        tick();
        updateIR = 1'b0;
        SelectIR = 1'b0;
        check("ir_o", 32'(ir), 32'(val));
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] dexp,
                           input logic do_update, output logic [31:0] so);
        captureDR = 1'b1;
        tick();
        captureDR = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(dexp[i]);
        so = '0;
        for (int i = 0; i < n; i++) begin
            so[i] = tdo;
            sample_tdo("dr_tdo");
            shiftDR = 1'b1;
            tdi     = din[i];
            tick();
        end
        shiftDR = 1'b0;
        if (do_update) begin
            updateDR = 1'b1;
            tick();
            updateDR = 1'b0;
        end
    endtask

    initial begin
        #1 trst = 1'b1;
        #11;
        check("rst_ir", 32'(ir), 32'h01);
        check("rst_wdata", user_wdata, 32'h0);
        check("rst_update", 32'(user_update), 32'h0);
        check("rst_tdo", 32'(tdo), 32'h0);
        check("oe_high", 32'(tdo_oe), 32'h1);
        @(negedge tck);
        #2 trst = 1'b0;

        // IDCODE after reset, streamed LSB first.
        dr_scan(32, 32'h0, IDCODE_VAL, 1'b0, dout);
        check("idcode_word", dout, 32'h1000_0A6F);

        // BYPASS: tdi 1,0,1,1 returns 0,1,0,1.
        ir_scan(5'h1F);
        dr_scan(4, 32'hD, 32'hA, 1'b0, dout);
        check("bypass_word", dout, 32'hA);

        // USER capture/shift/update.
        ir_scan(5'h10);
        user_rdata = 32'hDEAD_BEEF;
        dr_scan(32, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, dout);
        check("user_out", dout, 32'hDEAD_BEEF);
        check("user_pulse", 32'(user_update), 32'h1);
        check("user_wdata", user_wdata, 32'h1234_5678);
        tick();
        check("user_pulse_end", 32'(user_update), 32'h0);

        // Update-DR held for two states still gives a single-cycle strobe.
        updateDR = 1'b1;
        tick();
        check("hold_upd_1", 32'(user_update), 32'h1);
        tick();
        check("hold_upd_2", 32'(user_update), 32'h0);
        updateDR = 1'b0;

        // Undefined code acts as a 1-bit BYPASS and never strobes.
        ir_scan(5'h07);
        dr_scan(3, 32'h3, 32'h6, 1'b1, dout);
        check("undef_word", dout, 32'h6);
        check("undef_no_pulse", 32'(user_update), 32'h0);
        check("undef_wdata", user_wdata, 32'h1234_5678);

        Enable = 1'b0;
        #1 check("oe_low", 32'(tdo_oe), 32'h0);
        Enable = 1'b1;
        #1;

        // Reset in the middle of a USER scan aborts it.
        trst = 1'b1;
        #1 check("pre_wdata", user_wdata, 32'h0);
        @(negedge tck);
        #2 trst = 1'b0;
        ir_scan(5'h10);
        user_rdata = 32'hCAFE_F00D;
        captureDR = 1'b1;
        tick();
        captureDR = 1'b0;
        for (int i = 0; i < 9; i++) begin
            shiftDR = 1'b1;
            tdi     = 1'b1;
            tick();
        end
        @(posedge tck);
        #2 trst = 1'b1;
        #1;
        check("abort_ir", 32'(ir), 32'h01);
        check("abort_wdata", user_wdata, 32'h0);
        check("abort_update", 32'(user_update), 32'h0);
        check("abort_tdo", 32'(tdo), 32'h0);
        shiftDR = 1'b0;
        @(negedge tck);
        #2 trst = 1'b0;
        exp_q.delete();
        updateDR = 1'b1;
        tick();
        updateDR = 1'b0;
        check("post_no_pulse", 32'(user_update), 32'h0);
        check("post_wdata", user_wdata, 32'h0);
        dr_scan(32, 32'h0, IDCODE_VAL, 1'b0, dout);
        check("post_idcode", dout, 32'h1000_0A6F);

        // Capture and shift together: capture must win.
        captureDR = 1'b1;
        shiftDR   = 1'b1;
        tick();
        captureDR = 1'b0;
        check("prio_bit0", 32'(tdo), 32'(IDCODE_VAL[0]));
        tick();
        shiftDR = 1'b0;
        check("prio_bit1", 32'(tdo), 32'(IDCODE_VAL[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
